async_fifo_vr: RTL

Dual-clock FIFO with valid/ready handshakes on both sides, runtime-programmable almost-full/almost-empty thresholds, per-domain fill-level outputs and a configurable synchronizer depth. Gray-coded pointers cross the two clock domains. Capacity is 2^ASIZE words. The block sits on clock-domain boundaries in the grid fabric, between a producer in the wclk domain and a consumer in the rclk domain.

---
 rtl/async_fifo_vr.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/async_fifo_vr.sv
// Dual-clock FIFO with valid/ready on both sides, Gray-coded pointer crossing,
// registered fill levels and programmable almost-full / almost-empty flags.
module async_fifo_vr #(
    parameter int DSIZE       = 8,
    parameter int ASIZE       = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic             wclk,
    input  logic             wrst_n,
    input  logic             rclk,
    input  logic             rrst_n,
    input  logic             wvalid_i,
    output logic             wready_o,
    input  logic [DSIZE-1:0] wdata_i,
    input  logic [ASIZE:0]   afull_th_i,
    output logic [ASIZE:0]   wlevel_o,
    output logic             awfull_o,
    output logic             rvalid_o,
    input  logic             rready_i,
    output logic [DSIZE-1:0] rdata_o,
    input  logic [ASIZE:0]   aempty_th_i,
    output logic [ASIZE:0]   rlevel_o,
    output logic             arempty_o
);

    localparam int             DEPTH     = 1 << ASIZE;
    localparam logic [ASIZE:0] LVL_FULL  = {1'b1, {ASIZE{1'b0}}};
    localparam logic [ASIZE:0] LVL_ZERO  = {(ASIZE+1){1'b0}};

    function automatic logic [ASIZE:0] bin2gray(input logic [ASIZE:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [ASIZE:0] gray2bin(input logic [ASIZE:0] g);
        logic [ASIZE:0] b;
        b[ASIZE] = g[ASIZE];
        for (int i = ASIZE - 1; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    logic [DSIZE-1:0] mem_q [DEPTH];

    // write domain state
    logic [ASIZE:0] wbin_q, wbin_d, wgray_q, wgray_d;
    logic [ASIZE:0] wlevel_q, wlevel_d, wq_rbin_s;
    logic           wready_q, wready_d, awfull_q, awfull_d, waccept_s;
    logic [SYNC_STAGES-1:0][ASIZE:0] wq_rgray_q;

    // read domain state
    logic [ASIZE:0] rbin_q, rbin_d, rgray_q, rgray_d;
    logic [ASIZE:0] rlevel_q, rlevel_d, rq_wbin_s;
    logic           rvalid_q, rvalid_d, arempty_q, arempty_d, raccept_s;
    logic [SYNC_STAGES-1:0][ASIZE:0] rq_wgray_q;

    // Write-side next state; flags come from the post-accept pointer so full lands on the same edge.
    always_comb begin
        waccept_s = wvalid_i & wready_q;
        wbin_d    = wbin_q + {{ASIZE{1'b0}}, waccept_s};
        wgray_d   = bin2gray(wbin_d);
        wq_rbin_s = gray2bin(wq_rgray_q[SYNC_STAGES-1]);
        wlevel_d  = wbin_d - wq_rbin_s;
        wready_d  = (wlevel_d != LVL_FULL);
        if (afull_th_i == LVL_ZERO) begin
            awfull_d = 1'b1;
        end else if (afull_th_i > LVL_FULL) begin
            awfull_d = 1'b0;
        end else begin
            awfull_d = (wlevel_d >= afull_th_i);
        end
    end

    // Write pointer, flags and read-pointer synchronizer.
    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            wbin_q     <= LVL_ZERO;
            wgray_q    <= LVL_ZERO;
            wlevel_q   <= LVL_ZERO;
            wready_q   <= 1'b1;
            awfull_q   <= 1'b0;
            wq_rgray_q <= '0;
        end else begin
            wbin_q     <= wbin_d;
            wgray_q    <= wgray_d;
            wlevel_q   <= wlevel_d;
            wready_q   <= wready_d;
            awfull_q   <= awfull_d;
            wq_rgray_q <= {wq_rgray_q[SYNC_STAGES-2:0], rgray_q};
        end
    end

    // Storage array: synchronous write only, deliberately not reset.
    always_ff @(posedge wclk) begin
        if (waccept_s) begin
            mem_q[wbin_q[ASIZE-1:0]] <= wdata_i;
        end
    end

    // Read-side next state; rvalid drops on the same edge as the pop that empties the FIFO.
    always_comb begin
        raccept_s = rvalid_q & rready_i;
        rbin_d    = rbin_q + {{ASIZE{1'b0}}, raccept_s};
        rgray_d   = bin2gray(rbin_d);
        rq_wbin_s = gray2bin(rq_wgray_q[SYNC_STAGES-1]);
        rlevel_d  = rq_wbin_s - rbin_d;
        rvalid_d  = (rlevel_d != LVL_ZERO);
        if (aempty_th_i >= LVL_FULL) begin
            arempty_d = 1'b1;
        end else begin
            arempty_d = (rlevel_d <= aempty_th_i);
        end
    end

    // Read pointer, flags and write-pointer synchronizer.
    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            rbin_q     <= LVL_ZERO;
            rgray_q    <= LVL_ZERO;
            rlevel_q   <= LVL_ZERO;
            rvalid_q   <= 1'b0;
            arempty_q  <= 1'b1;
            rq_wgray_q <= '0;
        end else begin
            rbin_q     <= rbin_d;
            rgray_q    <= rgray_d;
            rlevel_q   <= rlevel_d;
            rvalid_q   <= rvalid_d;
            arempty_q  <= arempty_d;
            rq_wgray_q <= {rq_wgray_q[SYNC_STAGES-2:0], wgray_q};
        end
    end

    // A zero threshold must read as almost-full even while the write side is held in reset.
    assign awfull_o  = awfull_q | (afull_th_i == LVL_ZERO);
    assign wready_o  = wready_q;
    assign wlevel_o  = wlevel_q;
    assign rvalid_o  = rvalid_q;
    assign rlevel_o  = rlevel_q;
    assign arempty_o = arempty_q;
    assign rdata_o   = mem_q[rbin_q[ASIZE-1:0]];

endmodule
